// File: rtl/xor_hash_verificador_pkg.sv
// Shared definitions for the XOR line-hash blocks: hash width, checker FSM states
// and the byte-XOR reduction used by beat-level hashing.
package xor_hash_pkg;

    localparam int HASH_W    = 8;
    // Widest beat xor_bytes accepts; narrower beats are zero-extended, which leaves the XOR unchanged.
    localparam int XOR_MAX_W = 1024;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        RECEBENDO = 2'd1,
        RESULTADO = 2'd2
    } estado_verif_t;

    function automatic logic [HASH_W-1:0] xor_bytes(input logic [XOR_MAX_W-1:0] beat);
        logic [HASH_W-1:0] h;
        h = '0;
        for (int i = 0; i < XOR_MAX_W / HASH_W; i++) begin
            h ^= beat[i*HASH_W +: HASH_W];
        end
        return h;
    endfunction

endpackage

// File: rtl/xor_hash_verificador_if.sv
// Beat-input and result-output handshake bundle of the XOR hash checker.
// The slave modport is the checker; the master modport is the line source plus result consumer.
interface xor_hash_if
    import xor_hash_pkg::*;
#(
    parameter int BEAT_W = 64
);
    logic              entrada_valida;
    logic              entrada_pronta;
    logic [BEAT_W-1:0] entrada_dados;
    logic [HASH_W-1:0] hash_esperado;
    logic              resultado_valido;
    logic              resultado_pronto;
    logic [HASH_W-1:0] hash_calculado;
    logic              hash_ok;

    modport master (
        output entrada_valida, entrada_dados, hash_esperado, resultado_pronto,
        input  entrada_pronta, resultado_valido, hash_calculado, hash_ok
    );

    modport slave (
        input  entrada_valida, entrada_dados, hash_esperado, resultado_pronto,
        output entrada_pronta, resultado_valido, hash_calculado, hash_ok
    );
endinterface

// File: rtl/xor_hash_verificador_beat.sv
// Combinational BEAT_W -> 8 bit byte-XOR reduction of one beat; shared by the
// receive-side checker and any transmit-side hash generator.
module xor_hash_beat
    import xor_hash_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic [BEAT_W-1:0] beat_i,
    output logic [HASH_W-1:0] hash_o
);
    assign hash_o = xor_bytes(XOR_MAX_W'(beat_i));
endmodule

// File: rtl/xor_hash_verificador.sv
// Receive-side checker: folds a streamed cache line into its 8-bit XOR hash, one beat per cycle,
// and compares it to the hash sampled on beat 0. Define XOR_HASH_CONTADOR_ERROS_EN for the erros counter.
module xor_hash_verificador
    import xor_hash_pkg::*;
#(
    parameter int LINHA_W = 512,
    parameter int BEAT_W  = 64
) (
    input  logic        clk,
    input  logic        rst,
    xor_hash_if.slave   bus
`ifdef XOR_HASH_CONTADOR_ERROS_EN
    ,
    output logic [15:0] erros
`endif
);
    localparam int NUM_BEATS = LINHA_W / BEAT_W;
    localparam int CNT_W     = $clog2(NUM_BEATS) + 1;

    estado_verif_t     estado_q, estado_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HASH_W-1:0] acc_q, acc_d;
    logic [HASH_W-1:0] esp_q, esp_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic              ok_q, ok_d;

    logic [HASH_W-1:0] beat_xor;
    logic              pronto;
    logic              aceita;
    logic              entrega;
    logic              ultimo;

    xor_hash_beat #(.BEAT_W(BEAT_W)) u_beat (
        .beat_i (bus.entrada_dados),
        .hash_o (beat_xor)
    );

    assign pronto  = (estado_q != RESULTADO);
    assign aceita  = bus.entrada_valida && pronto;
    assign entrega = (estado_q == RESULTADO) && bus.resultado_pronto;
    assign ultimo  = ((estado_q == OCIOSO) && (NUM_BEATS == 1)) ||
                     ((estado_q == RECEBENDO) && (cnt_q == CNT_W'(NUM_BEATS - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            acc_q    <= '0;
            esp_q    <= '0;
            hash_q   <= '0;
            ok_q     <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            esp_q    <= esp_d;
            hash_q   <= hash_d;
            ok_q     <= ok_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:    if (aceita) estado_d = (NUM_BEATS == 1) ? RESULTADO : RECEBENDO;
            RECEBENDO: if (aceita && ultimo) estado_d = RESULTADO;
            RESULTADO: if (entrega) estado_d = OCIOSO;
            default:   estado_d = OCIOSO;
        endcase
    end

    // Result registers are loaded on the final beat so they are stable for the whole RESULTADO stay.
    always_comb begin
        acc_d  = acc_q;
        esp_d  = esp_q;
        cnt_d  = cnt_q;
        hash_d = hash_q;
        ok_d   = ok_q;
        if (aceita) begin
            if (estado_q == OCIOSO) begin
                acc_d = beat_xor;
                esp_d = bus.hash_esperado;
                cnt_d = CNT_W'(1);
            end else begin
                acc_d = acc_q ^ beat_xor;
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (ultimo) begin
                hash_d = acc_d;
                ok_d   = (acc_d == esp_d);
            end
        end
        if (entrega) cnt_d = '0;
    end

    always_comb begin
        bus.entrada_pronta   = pronto;
        bus.resultado_valido = (estado_q == RESULTADO);
        bus.hash_calculado   = hash_q;
        bus.hash_ok          = ok_q;
    end

`ifdef XOR_HASH_CONTADOR_ERROS_EN
    logic [15:0] erros_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            erros_q <= '0;
        end else if (entrega && !ok_q && (erros_q != 16'hFFFF)) begin
            erros_q <= erros_q + 16'd1;
        end
    end

    assign erros = erros_q;
`endif

endmodule

// File: tb/tb_xor_hash_verificador.sv
// Scoreboard bench for xor_hash_verificador: random lines, gaps, backpressure, resets and
// back-to-back traffic checked against a byte-array XOR reference model.
module tb_xor_hash_verificador;
    import xor_hash_pkg::*;

    localparam int LINHA_W = 512;
    localparam int BEAT_W  = 64;
    localparam int NB      = LINHA_W / BEAT_W;
    localparam int BPB     = BEAT_W / 8;
    localparam int NBYTES  = LINHA_W / 8;

    typedef struct {
        logic [7:0] h;
        logic       ok;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xor_hash_if #(.BEAT_W(BEAT_W)) bus ();

`ifdef XOR_HASH_CONTADOR_ERROS_EN
    logic [15:0] erros;
`endif

    xor_hash_verificador #(.LINHA_W(LINHA_W), .BEAT_W(BEAT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
`ifdef XOR_HASH_CONTADOR_ERROS_EN
        ,
        .erros (erros)
`endif
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         err_model = 0;
    exp_t       sb[$];
    int         hs_cyc[$];
    logic [7:0] ln[NBYTES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_hash();
        logic [7:0] h = 8'h00;
        for (int i = 0; i < NBYTES; i++) h ^= ln[i];
        return h;
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic [7:0] he);
        logic ok;
        int   n = 0;
        bus.entrada_valida = 1'b1;
        bus.entrada_dados  = d;
        bus.hash_esperado  = he;
        forever begin
            ok = bus.entrada_pronta;
            @(posedge clk);
            @(negedge clk);
            if (ok) break;
            n++;
            if (n > 200) begin
                chk("beat_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.entrada_valida = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] he0, input logic [7:0] he_rest,
                             input int max_gap, input int nbeats, input bit push);
        logic [BEAT_W-1:0] d;
        logic [7:0]        h;
        if (push) begin
            h = model_hash();
            sb.push_back('{h: h, ok: (h == he0)});
            if (h != he0) err_model++;
        end
        for (int k = 0; k < nbeats; k++) begin
            for (int j = 0; j < BPB; j++) d[BEAT_W-1-8*j -: 8] = ln[k*BPB + j];
            send_beat(d, (k == 0) ? he0 : he_rest);
            if (k == NB - 1) chk("latency_valid", bus.resultado_valido, 1);
            else if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_sb_empty", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic rand_line();
        for (int i = 0; i < NBYTES; i++) ln[i] = 8'($urandom);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pronta"}, bus.entrada_pronta, 1);
        chk({tag, "_valido"}, bus.resultado_valido, 0);
        chk({tag, "_hash"}, bus.hash_calculado, 0);
        chk({tag, "_ok"}, bus.hash_ok, 0);
    endtask

    // Monitor samples 1 time unit after each negedge, clear of stimulus driven on the negedge.
    initial begin
        logic       prev_held = 1'b0;
        logic [7:0] prev_h = 8'h00;
        logic       prev_ok = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_held = 1'b0;
            end else begin
                if (bus.resultado_valido) begin
                    chk("pronta_low_in_result", bus.entrada_pronta, 0);
                    if (prev_held) begin
                        chk("hold_hash", bus.hash_calculado, prev_h);
                        chk("hold_ok", bus.hash_ok, prev_ok);
                    end
                    if (bus.resultado_pronto) begin
                        hs_cyc.push_back(cyc);
                        if (sb.size() == 0) begin
                            chk("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("hash_calculado", bus.hash_calculado, e.h);
                            chk("hash_ok", bus.hash_ok, e.ok);
                        end
                    end
                end
                prev_held = bus.resultado_valido && !bus.resultado_pronto;
                prev_h    = bus.hash_calculado;
                prev_ok   = bus.hash_ok;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] he;
        int         n0;
        rst = 1'b1;
        bus.entrada_valida   = 1'b0;
        bus.entrada_dados    = '0;
        bus.hash_esperado    = 8'h00;
        bus.resultado_pronto = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Zero line
        for (int i = 0; i < NBYTES; i++) ln[i] = 8'h00;
        send_line(8'h00, 8'h00, 0, NB, 1'b1);
        drain();

        // Ramp line, matching then mismatching expected hash
        for (int i = 0; i < NBYTES; i++) ln[i] = 8'(i + 1);
        chk("ramp_model", model_hash(), 8'h40);
        send_line(8'h40, 8'h00, 0, NB, 1'b1);
        send_line(8'h41, 8'h00, 0, NB, 1'b1);
        drain();
`ifdef XOR_HASH_CONTADOR_ERROS_EN
        chk("erros_after_ramp", erros, 1);
`endif

        // Expected hash only sampled on beat 0
        rand_line();
        ln[NBYTES-1] = ln[NBYTES-1] ^ model_hash() ^ 8'h5A;
        send_line(8'h5A, 8'hFF, 0, NB, 1'b1);
        drain();

        // Same line gap-free, with gaps, then with gaps and held-off consumer
        rand_line();
        he = model_hash() ^ 8'($urandom_range(1, 0));
        send_line(he, 8'h00, 0, NB, 1'b1);
        drain();
        send_line(he, 8'h00, 3, NB, 1'b1);
        drain();
        bus.resultado_pronto = 1'b0;
        send_line(he, 8'h00, 3, NB, 1'b1);
        repeat (5) @(negedge clk);
        chk("bp_still_pending", sb.size(), 1);
        bus.resultado_pronto = 1'b1;
        drain();

        // Reset mid-line discards the partial line
        rand_line();
        send_line(8'h00, 8'h00, 0, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_midline");
        n0 = hs_cyc.size();
        for (int i = 0; i < NBYTES; i++) ln[i] = 8'hFF;
        send_line(8'h00, 8'h00, 0, NB, 1'b1);
        drain();
        chk("rst_midline_one_result", hs_cyc.size() - n0, 1);

        // Reset while a result is pending discards it
        rand_line();
        bus.resultado_pronto = 1'b0;
        send_line(8'h00, 8'h00, 0, NB, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.resultado_pronto = 1'b1;
        check_reset_state("rst_result");
        repeat (3) @(negedge clk);

        // Back-to-back lines
        n0 = hs_cyc.size();
        for (int l = 0; l < 3; l++) begin
            rand_line();
            send_line(model_hash(), 8'h00, 0, NB, 1'b1);
        end
        drain();
        chk("b2b_count", hs_cyc.size() - n0, 3);
        if (hs_cyc.size() - n0 == 3) begin
            chk("b2b_period_1", hs_cyc[n0+1] - hs_cyc[n0], NB + 1);
            chk("b2b_period_2", hs_cyc[n0+2] - hs_cyc[n0+1], NB + 1);
        end

        // Random traffic
        for (int l = 0; l < 20; l++) begin
            rand_line();
            he = ($urandom_range(1, 0) != 0) ? model_hash() : 8'($urandom);
            send_line(he, 8'($urandom), $urandom_range(2, 0), NB, 1'b1);
        end
        drain();
`ifdef XOR_HASH_CONTADOR_ERROS_EN
        chk("erros_final", erros, err_model);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
